bloco_inferencia: RTL and testbench

Type-2 fuzzy rule-inference stage sitting directly downstream of the fuzzifier block. It consumes the registered upper/lower membership degrees of the 3 sets of input 1 and the 3 sets of input 2, plus the 6-bit activity vector. It evaluates the 9 rules (set i of input 1 AND set j of input 2) sequentially, one rule per enabled cycle. It aggregates the firing intervals per consequent set by max, and hands the aggregated upper/lower degrees of 3 output sets to the type-reduction stage.

---
 rtl/bloco_inferencia.sv | 182 ++++++++++++++++++
 tb/tb_bloco_inferencia.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bloco_inferencia.sv
// Type-2 fuzzy rule inference: evaluates the 3x3 rule base one rule per enabled
// cycle on a snapshot of the fuzzifier outputs, max-aggregating per consequent set.
module bloco_inferencia #(
    parameter logic [1:0] CONS_11 = 2'd0,
    parameter logic [1:0] CONS_12 = 2'd0,
    parameter logic [1:0] CONS_13 = 2'd1,
    parameter logic [1:0] CONS_21 = 2'd0,
    parameter logic [1:0] CONS_22 = 2'd1,
    parameter logic [1:0] CONS_23 = 2'd2,
    parameter logic [1:0] CONS_31 = 2'd1,
    parameter logic [1:0] CONS_32 = 2'd2,
    parameter logic [1:0] CONS_33 = 2'd2,
    parameter int         W       = 8
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         EN_SCLK,
    input  logic         START,
    input  logic [5:0]   saida_Ativo_UP,
    input  logic [W-1:0] saida_01_UP,
    input  logic [W-1:0] saida_02_UP,
    input  logic [W-1:0] saida_03_UP,
    input  logic [W-1:0] saida_04_UP,
    input  logic [W-1:0] saida_05_UP,
    input  logic [W-1:0] saida_06_UP,
    input  logic [W-1:0] saida_01_LOW,
    input  logic [W-1:0] saida_02_LOW,
    input  logic [W-1:0] saida_03_LOW,
    input  logic [W-1:0] saida_04_LOW,
    input  logic [W-1:0] saida_05_LOW,
    input  logic [W-1:0] saida_06_LOW,
    output logic [W-1:0] agg_01_UP,
    output logic [W-1:0] agg_02_UP,
    output logic [W-1:0] agg_03_UP,
    output logic [W-1:0] agg_01_LOW,
    output logic [W-1:0] agg_02_LOW,
    output logic [W-1:0] agg_03_LOW,
    output logic [3:0]   n_regras,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [1:0] {IDLE, EVAL, FIN} state_t;

    // Rule idx = 3*(i-1) + (j-1); entry 0 is rule 11.
    localparam logic [8:0][1:0] CONS_TAB = {CONS_33, CONS_32, CONS_31,
                                            CONS_23, CONS_22, CONS_21,
                                            CONS_13, CONS_12, CONS_11};

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [5:0]          ativo_q, ativo_d;
    logic [5:0][W-1:0]   up_q, up_d, low_q, low_d;
    logic [2:0][W-1:0]   acc_up_q, acc_up_d, acc_low_q, acc_low_d;
    logic [2:0][W-1:0]   agg_up_q, agg_up_d, agg_low_q, agg_low_d;
    logic [3:0]          nreg_q, nreg_d;

    logic [2:0]          si, sj;
    logic [1:0]          cons;
    logic                rule_on;
    logic [W-1:0]        min_up, min_low, fire_up, fire_low;

    function automatic logic [W-1:0] fmin(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [W-1:0] fmax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Set indices are 0-based here: si in 0..2 (input 1), sj in 3..5 (input 2).
    always_comb begin
        si = 3'd2;
        sj = 3'd5;
        case (idx_q)
            4'd0, 4'd1, 4'd2: si = 3'd0;
            4'd3, 4'd4, 4'd5: si = 3'd1;
            default:          si = 3'd2;
        endcase
        case (idx_q)
            4'd0, 4'd3, 4'd6: sj = 3'd3;
            4'd1, 4'd4, 4'd7: sj = 3'd4;
            default:          sj = 3'd5;
        endcase
    end

    // Activity bit 5 belongs to set 1, so set s (0-based) maps to bit 5-s.
    assign cons     = CONS_TAB[idx_q];
    assign rule_on  = ativo_q[3'd5 - si] && ativo_q[3'd5 - sj] && (cons != 2'd3);
    assign min_up   = fmin(up_q[si], up_q[sj]);
    assign min_low  = fmin(fmin(low_q[si], low_q[sj]), min_up);
    assign fire_up  = rule_on ? min_up  : '0;
    assign fire_low = rule_on ? min_low : '0;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ativo_d   = ativo_q;
        up_d      = up_q;
        low_d     = low_q;
        acc_up_d  = acc_up_q;
        acc_low_d = acc_low_q;
        agg_up_d  = agg_up_q;
        agg_low_d = agg_low_q;
        nreg_d    = nreg_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    ativo_d   = saida_Ativo_UP;
                    up_d      = {saida_06_UP, saida_05_UP, saida_04_UP,
                                 saida_03_UP, saida_02_UP, saida_01_UP};
                    low_d     = {saida_06_LOW, saida_05_LOW, saida_04_LOW,
                                 saida_03_LOW, saida_02_LOW, saida_01_LOW};
                    acc_up_d  = '0;
                    acc_low_d = '0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                if (cons != 2'd3) begin
                    acc_up_d[cons]  = fmax(acc_up_q[cons], fire_up);
                    acc_low_d[cons] = fmax(acc_low_q[cons], fire_low);
                end
                if (fire_up != '0) cnt_d = cnt_q + 4'd1;
                if (idx_q == 4'd8) begin
                    agg_up_d  = acc_up_d;
                    agg_low_d = acc_low_d;
                    nreg_d    = cnt_d;
                    state_d   = FIN;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            ativo_q   <= '0;
            up_q      <= '0;
            low_q     <= '0;
            acc_up_q  <= '0;
            acc_low_q <= '0;
            agg_up_q  <= '0;
            agg_low_q <= '0;
            nreg_q    <= '0;
        end else if (EN_SCLK) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ativo_q   <= ativo_d;
            up_q      <= up_d;
            low_q     <= low_d;
            acc_up_q  <= acc_up_d;
            acc_low_q <= acc_low_d;
            agg_up_q  <= agg_up_d;
            agg_low_q <= agg_low_d;
            nreg_q    <= nreg_d;
        end
    end

    // DONE follows FIN, so it naturally holds across disabled cycles.
    assign BUSY       = (state_q == EVAL);
    assign DONE       = (state_q == FIN);
    assign agg_01_UP  = agg_up_q[0];
    assign agg_02_UP  = agg_up_q[1];
    assign agg_03_UP  = agg_up_q[2];
    assign agg_01_LOW = agg_low_q[0];
    assign agg_02_LOW = agg_low_q[1];
    assign agg_03_LOW = agg_low_q[2];
    assign n_regras   = nreg_q;

endmodule

// File: tb/tb_bloco_inferencia.sv
// Bench for bloco_inferencia: table of input/expected records fed through a
// scoreboard queue, plus hand sequences for gating, snapshot, START-while-busy and reset.
module tb_bloco_inferencia;

    logic            clk = 1'b0;
    logic            RESET, EN_SCLK, START;
    logic [5:0]      ativo;
    logic [5:0][7:0] up, low;
    logic [7:0]      a1u, a2u, a3u, a1l, a2l, a3l;
    logic [3:0]      n_regras;
    logic            BUSY, DONE;

    int tests = 0;
    int fails = 0;
    bit gate  = 1'b0;

    typedef struct {
        logic [5:0]      ativo;
        logic [5:0][7:0] up;    // [0] = set 1
        logic [5:0][7:0] low;
        logic [2:0][7:0] eup;   // [0] = output set 1
        logic [2:0][7:0] elow;
        logic [3:0]      en;
    } vec_t;

    vec_t vecs[6];
    vec_t sbq[$];

    always #5 clk = ~clk;

    bloco_inferencia dut (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .START(START),
        .saida_Ativo_UP(ativo),
        .saida_01_UP(up[0]), .saida_02_UP(up[1]), .saida_03_UP(up[2]),
        .saida_04_UP(up[3]), .saida_05_UP(up[4]), .saida_06_UP(up[5]),
        .saida_01_LOW(low[0]), .saida_02_LOW(low[1]), .saida_03_LOW(low[2]),
        .saida_04_LOW(low[3]), .saida_05_LOW(low[4]), .saida_06_LOW(low[5]),
        .agg_01_UP(a1u), .agg_02_UP(a2u), .agg_03_UP(a3u),
        .agg_01_LOW(a1l), .agg_02_LOW(a2l), .agg_03_LOW(a3l),
        .n_regras(n_regras), .BUSY(BUSY), .DONE(DONE)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock; reports whether that edge was enabled. Inputs change 1 ns after the edge.
    task automatic tick(output bit en);
        en = EN_SCLK;
        @(posedge clk);
        #1;
        if (gate) EN_SCLK = ~EN_SCLK;
    endtask

    task automatic run(input vec_t v, input bit scramble, input bit poke);
        bit   en;
        int   edges, guard;
        vec_t e;
        ativo = v.ativo; up = v.up; low = v.low; START = 1'b1;
        guard = 0;
        do begin tick(en); guard++; end while (!en && guard < 10);
        START = 1'b0;
        sbq.push_back(v);
        edges = 1;
        if (scramble) begin ativo = '1; up = '1; low = '1; end
        guard = 0;
        while (!DONE && guard < 200) begin
            tick(en);
            guard++;
            if (en) edges++;
            START = poke && (edges == 5);
            if (DONE && BUSY) check("done_busy_overlap", 1, 0);
        end
        START = 1'b0;
        check("done_seen", DONE, 1);
        check("latency", edges, 10);
        check("busy_at_done", BUSY, 0);
        e = sbq.pop_front();
        check("agg_up",  {a3u, a2u, a1u}, e.eup);
        check("agg_low", {a3l, a2l, a1l}, e.elow);
        check("n_regras", n_regras, e.en);
        tick(en);
        if (!en) begin
            check("done_hold", DONE, 1);
            tick(en);
        end
        check("done_fall", DONE, 0);
        tick(en); tick(en);
        check("idle_busy", BUSY, 0);
        check("idle_done", DONE, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit en;
        // single pair 1x4, LOW clamped to UP
        vecs[0].ativo = 6'b100100;
        vecs[0].up    = {8'd0, 8'd0, 8'd120, 8'd0, 8'd0, 8'd200};
        vecs[0].low   = {8'd0, 8'd0, 8'd180, 8'd0, 8'd0, 8'd150};
        vecs[0].eup   = {8'd0, 8'd0, 8'd120};
        vecs[0].elow  = {8'd0, 8'd0, 8'd120};
        vecs[0].en    = 4'd1;
        // max aggregation over rules 11/12/21 and rule 22
        vecs[1].ativo = 6'b111111;
        vecs[1].up    = {8'd0, 8'd60, 8'd100, 8'd0, 8'd90, 8'd100};
        vecs[1].low   = {8'd0, 8'd40, 8'd80,  8'd0, 8'd90, 8'd80};
        vecs[1].eup   = {8'd0, 8'd60, 8'd100};
        vecs[1].elow  = {8'd0, 8'd40, 8'd80};
        vecs[1].en    = 4'd4;
        // everything saturated
        vecs[2].ativo = 6'b111111;
        vecs[2].up    = '1;
        vecs[2].low   = '1;
        vecs[2].eup   = {8'd255, 8'd255, 8'd255};
        vecs[2].elow  = {8'd255, 8'd255, 8'd255};
        vecs[2].en    = 4'd9;
        // nothing active
        vecs[3].ativo = 6'b000000;
        vecs[3].up    = '1;
        vecs[3].low   = '1;
        vecs[3].eup   = '0;
        vecs[3].elow  = '0;
        vecs[3].en    = 4'd0;
        // only rule 33 -> output set 3
        vecs[4].ativo = 6'b001001;
        vecs[4].up    = {8'd90, 8'd0, 8'd0, 8'd77, 8'd0, 8'd0};
        vecs[4].low   = {8'd60, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0};
        vecs[4].eup   = {8'd77, 8'd0, 8'd0};
        vecs[4].elow  = {8'd50, 8'd0, 8'd0};
        vecs[4].en    = 4'd1;
        // sets 1,2,5,6 active; inactive sets carry 255 that must not leak
        vecs[5].ativo = 6'b110011;
        vecs[5].up    = {8'd5, 8'd150, 8'd255, 8'd255, 8'd200, 8'd40};
        vecs[5].low   = {8'd5, 8'd100, 8'd255, 8'd255, 8'd10,  8'd30};
        vecs[5].eup   = {8'd5, 8'd150, 8'd40};
        vecs[5].elow  = {8'd5, 8'd10,  8'd30};
        vecs[5].en    = 4'd4;

        RESET = 1'b1; EN_SCLK = 1'b1; START = 1'b0;
        ativo = '0; up = '0; low = '0;
        repeat (3) tick(en);
        check("rst_agg_up",  {a3u, a2u, a1u}, 0);
        check("rst_agg_low", {a3l, a2l, a1l}, 0);
        check("rst_n_regras", n_regras, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RESET = 1'b0;
        tick(en);

        for (int k = 0; k < 6; k++) run(vecs[k], 1'b0, 1'b0);

        // enable toggling every clock
        gate = 1'b1;
        run(vecs[1], 1'b0, 1'b0);
        gate = 1'b0;
        EN_SCLK = 1'b1;
        tick(en);

        // inputs change right after START, then re-evaluate the new inputs
        run(vecs[1], 1'b1, 1'b0);
        run(vecs[2], 1'b0, 1'b0);

        // START pulsed mid-evaluation must be ignored
        run(vecs[1], 1'b0, 1'b1);

        // reset mid-EVAL
        ativo = vecs[1].ativo; up = vecs[1].up; low = vecs[1].low; START = 1'b1;
        tick(en);
        START = 1'b0;
        repeat (4) tick(en);
        check("mid_busy", BUSY, 1);
        RESET = 1'b1;
        #1;
        check("arst_agg_up",  {a3u, a2u, a1u}, 0);
        check("arst_agg_low", {a3l, a2l, a1l}, 0);
        check("arst_n_regras", n_regras, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        tick(en);
        RESET = 1'b0;
        tick(en);
        run(vecs[5], 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
